// File: rtl/low_power_ifft_if.sv
// Streaming bus for low_power_ifft: serial complex spectrum in, serial time samples out.
// The master modport drives the spectrum; the slave modport is the IFFT itself.
interface low_power_ifft_if #(
  parameter int width = 9
) ();
  logic                    vld_in;
  logic signed [width-1:0] in_r;
  logic signed [width-1:0] in_i;
  logic                    ready;
  logic signed [width-1:0] out_r;
  logic signed [width-1:0] out_i;
  logic                    vld_out;

  modport master (
    output vld_in, in_r, in_i,
    input  ready, out_r, out_i, vld_out
  );

  modport slave (
    input  vld_in, in_r, in_i,
    output ready, out_r, out_i, vld_out
  );
endinterface

// File: rtl/low_power_ifft.sv
// Eight-point radix-2 DIT inverse FFT: bit-reversed load, three time-shared butterfly stages, serial output.
// Define LP_IFFT_SCALE_EN to scale results by 1/8 before saturation; otherwise outputs are the unnormalised 8x IDFT.
module low_power_ifft #(
  parameter int width = 9,
  parameter int FRAC  = 7
) (
  input  logic            clk,
  input  logic            rst,
  low_power_ifft_if.slave bus
);

  localparam int IW   = width + 4;
  localparam int PW   = 2 * IW;
  // round(0.70710678 * 2^FRAC), from a 16-bit fixed-point approximation of 1/sqrt(2)
  localparam int CW   = (46341 * (1 << FRAC) + 32768) / 65536;
  localparam int OMAX = (1 << (width - 1)) - 1;
  localparam int OMIN = -(1 << (width - 1));

  localparam logic [1:0] W_ONE = 2'd0;
  localparam logic [1:0] W_P45 = 2'd1;
  localparam logic [1:0] W_J   = 2'd2;
  localparam logic [1:0] W_M45 = 2'd3;

  typedef enum logic [2:0] {LOAD, STG0, STG1, STG2, OUT} state_t;
  typedef logic signed [IW-1:0] samp_t;

  state_t                  state_q, state_d;
  logic [2:0]              kCnt_q, kCnt_d;
  logic [2:0]              nCnt_q, nCnt_d;
  samp_t                   bR_q [8];
  samp_t                   bI_q [8];
  samp_t                   bR_d [8];
  samp_t                   bI_d [8];
  logic signed [width-1:0] outR_q, outR_d;
  logic signed [width-1:0] outI_q, outI_d;
  logic                    vldOut_q, vldOut_d;

  logic [1:0]              stg;
  logic [7:0]              cfg;
  logic [2*IW-1:0]         prod;
  samp_t                   twR, twI;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Packs {top index, bottom index, twiddle select} for butterfly m of stage s
  function automatic logic [7:0] pairCfg(input logic [1:0] s, input logic [1:0] m);
    logic [2:0] p, q;
    logic [1:0] w;
    case (s)
      2'd0: begin
        p = {m, 1'b0};
        q = {m, 1'b1};
        w = W_ONE;
      end
      2'd1: begin
        p = {m[0], 1'b0, m[1]};
        q = {m[0], 1'b1, m[1]};
        w = m[1] ? W_J : W_ONE;
      end
      default: begin
        p = {1'b0, m};
        q = {1'b1, m};
        w = m;
      end
    endcase
    return {p, q, w};
  endfunction

  // Conjugate twiddles: +-1 and +j are swap/negate only, the 45-degree ones floor the full product
  function automatic logic [2*IW-1:0] twMul(input samp_t br, input samp_t bi, input logic [1:0] sel);
    logic signed [PW-1:0] brx, bix, ck, pr, pi;
    samp_t tr, ti;
    brx = br;
    bix = bi;
    ck  = PW'(CW);
    tr  = br;
    ti  = bi;
    pr  = '0;
    pi  = '0;
    case (sel)
      W_ONE: ;
      W_J: begin
        tr = -bi;
        ti = br;
      end
      W_P45: begin
        pr = brx * ck - bix * ck;
        pi = brx * ck + bix * ck;
        tr = samp_t'(pr >>> FRAC);
        ti = samp_t'(pi >>> FRAC);
      end
      default: begin
        pr = -(brx * ck) - bix * ck;
        pi = brx * ck - bix * ck;
        tr = samp_t'(pr >>> FRAC);
        ti = samp_t'(pi >>> FRAC);
      end
    endcase
    return {tr, ti};
  endfunction

  function automatic logic signed [width-1:0] outStage(input samp_t v);
    samp_t s;
`ifdef LP_IFFT_SCALE_EN
    s = v >>> 3;
`else
    s = v;
`endif
    if (s > samp_t'(OMAX)) return width'(OMAX);
    if (s < samp_t'(OMIN)) return width'(OMIN);
    return s[width-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      kCnt_q   <= '0;
      nCnt_q   <= '0;
      bR_q     <= '{default: '0};
      bI_q     <= '{default: '0};
      outR_q   <= '0;
      outI_q   <= '0;
      vldOut_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      kCnt_q   <= kCnt_d;
      nCnt_q   <= nCnt_d;
      bR_q     <= bR_d;
      bI_q     <= bI_d;
      outR_q   <= outR_d;
      outI_q   <= outI_d;
      vldOut_q <= vldOut_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kCnt_d   = kCnt_q;
    nCnt_d   = nCnt_q;
    bR_d     = bR_q;
    bI_d     = bI_q;
    outR_d   = outR_q;
    outI_d   = outI_q;
    vldOut_d = 1'b0;
    stg      = 2'd0;
    cfg      = '0;
    prod     = '0;
    twR      = '0;
    twI      = '0;

    case (state_q)
      LOAD: begin
        if (bus.vld_in) begin
          bR_d[bitrev3(kCnt_q)] = {{4{bus.in_r[width-1]}}, bus.in_r};
          bI_d[bitrev3(kCnt_q)] = {{4{bus.in_i[width-1]}}, bus.in_i};
          kCnt_d = kCnt_q + 3'd1;
          if (kCnt_q == 3'd7) state_d = STG0;
        end
      end
      STG0: begin
        stg     = 2'd0;
        state_d = STG1;
      end
      STG1: begin
        stg     = 2'd1;
        state_d = STG2;
      end
      STG2: begin
        stg     = 2'd2;
        state_d = OUT;
      end
      OUT: begin
        outR_d   = outStage(bR_q[nCnt_q]);
        outI_d   = outStage(bI_q[nCnt_q]);
        vldOut_d = 1'b1;
        nCnt_d   = nCnt_q + 3'd1;
        if (nCnt_q == 3'd7) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase

    if (state_q == STG0 || state_q == STG1 || state_q == STG2) begin
      for (int m = 0; m < 4; m++) begin
        cfg  = pairCfg(stg, m[1:0]);
        prod = twMul(bR_q[cfg[4:2]], bI_q[cfg[4:2]], cfg[1:0]);
        twR  = prod[2*IW-1:IW];
        twI  = prod[IW-1:0];
        bR_d[cfg[7:5]] = bR_q[cfg[7:5]] + twR;
        bI_d[cfg[7:5]] = bI_q[cfg[7:5]] + twI;
        bR_d[cfg[4:2]] = bR_q[cfg[7:5]] - twR;
        bI_d[cfg[4:2]] = bI_q[cfg[7:5]] - twI;
      end
    end
  end

  assign bus.ready   = (state_q == LOAD);
  assign bus.out_r   = outR_q;
  assign bus.out_i   = outI_q;
  assign bus.vld_out = vldOut_q;

endmodule

// File: tb/tb_low_power_ifft.sv
// Directed-vector bench for low_power_ifft; expected outputs are hand-computed pre-output-stage values
// passed through a small model of the scale/saturate stage so the bench follows either build.
module tb_low_power_ifft;

  localparam int W = 9;

  logic clk = 1'b0;
  logic rst;

  low_power_ifft_if #(.width(W)) bus ();

  low_power_ifft #(.width(W), .FRAC(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stimR [8];
  int stimI [8];
  int expR  [8];
  int expI  [8];

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int modelOut(input int v);
    int s;
`ifdef LP_IFFT_SCALE_EN
    s = v >>> 3;
`else
    s = v;
`endif
    if (s > 255) s = 255;
    if (s < -256) s = -256;
    return s;
  endfunction

  task automatic clearFrame();
    for (int i = 0; i < 8; i++) begin
      stimR[i] = 0;
      stimI[i] = 0;
      expR[i]  = 0;
      expI[i]  = 0;
    end
  endtask

  // Loads one frame, then watches E0..E12, optionally hammering vld_in while busy
  task automatic applyStimulus(input string name, input bit busyDrop);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s ready_load%0d", name, k), int'(bus.ready), 1);
      bus.vld_in = 1'b1;
      bus.in_r   = W'(stimR[k]);
      bus.in_i   = W'(stimI[k]);
    end
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (busyDrop && c <= 10) begin
        bus.vld_in = 1'b1;
        bus.in_r   = W'(100);
        bus.in_i   = W'(100);
      end else begin
        bus.vld_in = 1'b0;
      end
      checkOutput($sformatf("%s ready_c%0d", name, c), int'(bus.ready), int'(c >= 11));
      checkOutput($sformatf("%s vld_c%0d", name, c), int'(bus.vld_out), int'(c >= 4 && c <= 11));
      if (c >= 4 && c <= 11) begin
        checkOutput($sformatf("%s x%0d_r", name, c - 4), int'($signed(bus.out_r)), modelOut(expR[c-4]));
        checkOutput($sformatf("%s x%0d_i", name, c - 4), int'($signed(bus.out_i)), modelOut(expI[c-4]));
      end
      if (c == 12) begin
        checkOutput($sformatf("%s hold_r", name), int'($signed(bus.out_r)), modelOut(expR[7]));
        checkOutput($sformatf("%s hold_i", name), int'($signed(bus.out_i)), modelOut(expI[7]));
      end
    end
    bus.vld_in = 1'b0;
  endtask

  task automatic checkIdle(input string name);
    checkOutput($sformatf("%s ready", name), int'(bus.ready), 1);
    checkOutput($sformatf("%s vld", name), int'(bus.vld_out), 0);
    checkOutput($sformatf("%s out_r", name), int'($signed(bus.out_r)), 0);
    checkOutput($sformatf("%s out_i", name), int'($signed(bus.out_i)), 0);
  endtask

  task automatic setDcFrame();
    clearFrame();
    stimR[0] = 64;
    for (int i = 0; i < 8; i++) expR[i] = 64;
  endtask

  task automatic setSingleBinFrame();
    clearFrame();
    stimR[1] = 64;
    expR = '{64, 45, 0, -46, -64, -45, 0, 46};
    expI = '{0, 45, 64, 45, 0, -45, -64, -45};
  endtask

  initial begin
    rst        = 1'b1;
    bus.vld_in = 1'b0;
    bus.in_r   = '0;
    bus.in_i   = '0;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;

    $display("[TB] flat spectrum");
    clearFrame();
    for (int i = 0; i < 8; i++) stimR[i] = 64;
    expR[0] = 512;
    applyStimulus("flat", 1'b0);

    $display("[TB] DC bin");
    setDcFrame();
    applyStimulus("dc", 1'b0);

    $display("[TB] single bin");
    setSingleBinFrame();
    applyStimulus("bin1", 1'b0);

    $display("[TB] two bins at full scale");
    clearFrame();
    stimR[0] = 255;
    stimR[1] = 255;
    expR = '{510, 436, 255, 73, 0, 74, 255, 437};
    expI = '{0, 181, 255, 181, 0, -181, -255, -181};
    applyStimulus("sat", 1'b0);

    $display("[TB] input while busy");
    setSingleBinFrame();
    applyStimulus("busy", 1'b1);
    setDcFrame();
    applyStimulus("afterbusy", 1'b0);

    $display("[TB] reset mid-load");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.vld_in = 1'b1;
      bus.in_r   = W'(100);
      bus.in_i   = W'(100);
    end
    @(negedge clk);
    bus.vld_in = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdle("midreset");
    setDcFrame();
    applyStimulus("afterreset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
